// File: rtl/core_pkg.sv
// Shared core definitions: multiplier op encodings and exception codes.
package core_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_t;

    localparam logic [2:0] EXC_NONE          = 3'b000;
    localparam logic [2:0] EXC_ILLEGAL_INSTR = 3'b010;

endpackage

// File: rtl/mul_stage_reg.sv
// One multiplier pipeline stage: valid, result, ROB tag and exception.
module mul_stage_reg #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned EXC_W     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [XLEN-1:0]      in_data,
    input  logic [ROB_IDX_W-1:0] in_rob_idx,
    input  logic [EXC_W-1:0]     in_exc,
    output logic                 out_valid,
    output logic [XLEN-1:0]      out_data,
    output logic [ROB_IDX_W-1:0] out_rob_idx,
    output logic [EXC_W-1:0]     out_exc
);

    // Flush kills the valid bit even while stalled; payload only moves when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_rob_idx <= '0;
            out_exc     <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (en) begin
                out_valid <= in_valid;
            end
            if (en && !flush) begin
                out_data    <= in_data;
                out_rob_idx <= in_rob_idx;
                out_exc     <= in_exc;
            end
        end
    end

endmodule

// File: rtl/mul_pipe_ex.sv
// Pipelined RV32 M-extension multiplier (EX stage).
// Build option: MUL_HIGH_EN enables MULH/MULHSU/MULHU; otherwise only MUL,
// and other ops report EXC_ILLEGAL_INSTR.
module mul_pipe_ex
    import core_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned EXC_W     = 3,
    parameter int unsigned STAGES    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [XLEN-1:0]      in_data_a,
    input  logic [XLEN-1:0]      in_data_b,
    input  logic [ROB_IDX_W-1:0] in_rob_idx,
    input  logic [EXC_W-1:0]     in_exception_vector,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic [ROB_IDX_W-1:0] out_rob_idx,
    output logic [EXC_W-1:0]     out_exception_vector
);

    logic    stall;
    mul_op_t op;

    logic [XLEN-1:0]  calc_result_c;
    logic [EXC_W-1:0] calc_exc_c;

    logic [STAGES-1:0]                st_valid;
    logic [STAGES-1:0][XLEN-1:0]      st_data;
    logic [STAGES-1:0][ROB_IDX_W-1:0] st_rob;
    logic [STAGES-1:0][EXC_W-1:0]     st_exc;

    // Any output backpressure freezes the whole pipe.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign op       = mul_op_t'(in_op);

`ifdef MUL_HIGH_EN
    localparam int unsigned PW = 2 * XLEN + 2;

    logic          a_sgn;
    logic          b_sgn;
    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] prod;
    logic          prod_top_unused;

    // Sign-extend per op, then one wide multiply covers all four variants.
    always_comb begin
        a_sgn = ((op == MUL_OP_MULH) || (op == MUL_OP_MULHSU)) && in_data_a[XLEN-1];
        b_sgn = (op == MUL_OP_MULH) && in_data_b[XLEN-1];
        a_ext = {{(PW-XLEN){a_sgn}}, in_data_a};
        b_ext = {{(PW-XLEN){b_sgn}}, in_data_b};
        prod  = a_ext * b_ext;
    end

    assign prod_top_unused = ^prod[PW-1:2*XLEN];

    // Select product half; excepted ops carry a zero result.
    always_comb begin
        calc_result_c = '0;
        calc_exc_c    = in_exception_vector;
        if (in_exception_vector == EXC_W'(EXC_NONE)) begin
            if (op == MUL_OP_MUL) begin
                calc_result_c = prod[XLEN-1:0];
            end else begin
                calc_result_c = prod[2*XLEN-1:XLEN];
            end
        end
    end
`else
    logic [XLEN-1:0] prod_lo;

    assign prod_lo = in_data_a * in_data_b;

    // Low-half only; upper-half ops are flagged illegal.
    always_comb begin
        calc_result_c = '0;
        calc_exc_c    = in_exception_vector;
        if (in_exception_vector == EXC_W'(EXC_NONE)) begin
            if (op == MUL_OP_MUL) begin
                calc_result_c = prod_lo;
            end else begin
                calc_exc_c = EXC_W'(EXC_ILLEGAL_INSTR);
            end
        end
    end
`endif

    // Stage chain: stage 0 captures the computed result, later stages shift it along.
    genvar i;
    generate
        for (i = 0; i < STAGES; i++) begin : g_stage
            if (i == 0) begin : g_first
                mul_stage_reg #(
                    .XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .EXC_W(EXC_W)
                ) u_reg (
                    .clk(clk), .reset(reset), .en(!stall), .flush(flush),
                    .in_valid(in_valid), .in_data(calc_result_c),
                    .in_rob_idx(in_rob_idx), .in_exc(calc_exc_c),
                    .out_valid(st_valid[i]), .out_data(st_data[i]),
                    .out_rob_idx(st_rob[i]), .out_exc(st_exc[i])
                );
            end else begin : g_next
                mul_stage_reg #(
                    .XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .EXC_W(EXC_W)
                ) u_reg (
                    .clk(clk), .reset(reset), .en(!stall), .flush(flush),
                    .in_valid(st_valid[i-1]), .in_data(st_data[i-1]),
                    .in_rob_idx(st_rob[i-1]), .in_exc(st_exc[i-1]),
                    .out_valid(st_valid[i]), .out_data(st_data[i]),
                    .out_rob_idx(st_rob[i]), .out_exc(st_exc[i])
                );
            end
        end
    endgenerate

    assign out_valid            = st_valid[STAGES-1];
    assign out_result           = st_data[STAGES-1];
    assign out_rob_idx          = st_rob[STAGES-1];
    assign out_exception_vector = st_exc[STAGES-1];

endmodule

// File: tb/tb_mul_pipe_ex.sv
// Self-checking bench for mul_pipe_ex: scoreboard of expected results in accept order.
module tb_mul_pipe_ex;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  rob;
        logic [2:0]  exc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_data_a;
    logic [31:0] in_data_b;
    logic [3:0]  in_rob_idx;
    logic [2:0]  in_exception_vector;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_rob_idx;
    logic [2:0]  out_exception_vector;

    exp_t sb[$];
    exp_t held;
    bit   held_valid;
    bit   done;
    int   n_checks;
    int   n_fail;

    mul_pipe_ex dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_data_a(in_data_a), .in_data_b(in_data_b),
        .in_rob_idx(in_rob_idx), .in_exception_vector(in_exception_vector),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rob_idx(out_rob_idx), .out_exception_vector(out_exception_vector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit product of per-op extended operands.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] rob, input logic [2:0] exc);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        exp_t e;
        e.rob = rob;
        e.exc = exc;
        e.res = 32'h0;
        ea = {32'h0, a};
        eb = {32'h0, b};
        if ((op == 2'b01 || op == 2'b10) && a[31]) ea[63:32] = 32'hFFFFFFFF;
        if (op == 2'b01 && b[31]) eb[63:32] = 32'hFFFFFFFF;
        p = ea * eb;
        if (exc == 3'b000) begin
`ifdef MUL_HIGH_EN
            e.res = (op == 2'b00) ? p[31:0] : p[63:32];
`else
            if (op == 2'b00) e.res = p[31:0];
            else e.exc = 3'b010;
`endif
        end
        return e;
    endfunction

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_result", 64'(out_result), 64'(held.res));
                check("hold_rob", 64'(out_rob_idx), 64'(held.rob));
                check("hold_exc", 64'(out_exception_vector), 64'(held.exc));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 64'(out_valid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("result", 64'(out_result), 64'(e.res));
                    check("rob_idx", 64'(out_rob_idx), 64'(e.rob));
                    check("exc", 64'(out_exception_vector), 64'(e.exc));
                end
            end
            held_valid = out_valid && !out_ready && !flush;
            held = '{res: out_result, rob: out_rob_idx, exc: out_exception_vector};
            if (flush) sb.delete();
            else if (in_valid && in_ready)
                sb.push_back(model(in_op, in_data_a, in_data_b, in_rob_idx, in_exception_vector));
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] rob, input logic [2:0] exc);
        bit ok;
        int n;
        in_valid = 1'b1;
        in_op = op;
        in_data_a = a;
        in_data_b = b;
        in_rob_idx = rob;
        in_exception_vector = exc;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("send_accept", 64'(ok), 64'(1));
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 64'(sb.size()), 64'(0));
    endtask

    task automatic count_valid(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int cnt;
        exp_t e;
        n_checks = 0;
        n_fail = 0;
        done = 1'b0;
        reset = 1'b1;
        in_valid = 1'b0;
        in_op = 2'b00;
        in_data_a = 32'h0;
        in_data_b = 32'h0;
        in_rob_idx = 4'h0;
        in_exception_vector = 3'h0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_result", 64'(out_result), 64'(0));
        check("rst_out_rob", 64'(out_rob_idx), 64'(0));
        check("rst_out_exc", 64'(out_exception_vector), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Single MUL, latency
        send(2'b00, 32'd7, 32'd6, 4'd3, 3'b000);
        idle();
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(4));
        check("mul_7x6", 64'(out_result), 64'(42));
        check("mul_7x6_rob", 64'(out_rob_idx), 64'(3));
        drain();

        // All-ones operands, every op, back to back
        for (int k = 0; k < 4; k++) send(2'(k), 32'hFFFFFFFF, 32'hFFFFFFFF, 4'(k + 4), 3'b000);
        send(2'b01, 32'h80000000, 32'h7FFFFFFF, 4'd8, 3'b000);
        send(2'b10, 32'h80000000, 32'hFFFFFFFF, 4'd9, 3'b000);
        idle();
        drain();

        // Stall at first out_valid
        out_ready = 1'b0;
        send(2'b00, 32'd3, 32'd5, 4'd1, 3'b000);
        send(2'b00, 32'd100, 32'd200, 4'd2, 3'b000);
        send(2'b11, 32'h12345678, 32'h9ABCDEF0, 4'd3, 3'b000);
        send(2'b01, 32'hDEADBEEF, 32'h00000010, 4'd4, 3'b000);
        idle();
        e = model(2'b00, 32'd3, 32'd5, 4'd1, 3'b000);
        check("stall_out_valid", 64'(out_valid), 64'(1));
        check("stall_in_ready", 64'(in_ready), 64'(0));
        check("stall_first_result", 64'(out_result), 64'(e.res));
        repeat (3) @(posedge clk);
        #1;
        check("stall_in_ready_held", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        drain();

        // Flush with 3 ops in flight and a new op the same cycle
        send(2'b00, 32'd11, 32'd12, 4'd5, 3'b000);
        send(2'b00, 32'd13, 32'd14, 4'd6, 3'b000);
        send(2'b00, 32'd15, 32'd16, 4'd7, 3'b000);
        in_valid = 1'b1;
        in_data_a = 32'd17;
        in_rob_idx = 4'd8;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        idle();
        check("flush_valid_next", 64'(out_valid), 64'(0));
        count_valid(8, cnt);
        check("flush_no_out", 64'(cnt), 64'(0));

        // Upstream exception passes through unchanged
        send(2'b00, 32'd5, 32'd6, 4'd9, 3'b101);
        send(2'b01, 32'd5, 32'd6, 4'd10, 3'b101);
        send(2'b01, 32'd5, 32'd6, 4'd11, 3'b000);
        idle();
        drain();

        // Random traffic with random backpressure
        fork
            begin
                for (int k = 0; k < 120; k++) begin
                    logic [31:0] a;
                    logic [31:0] b;
                    logic [2:0]  x;
                    case ($urandom_range(0, 3))
                        0: a = 32'h0;
                        1: a = 32'hFFFFFFFF;
                        2: a = 32'h80000000;
                        default: a = $urandom;
                    endcase
                    b = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
                    x = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                    send(2'($urandom_range(0, 3)), a, b, 4'(k), x);
                    if ($urandom_range(0, 2) == 0) begin
                        idle();
                        @(posedge clk);
                        #1;
                    end
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #2;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with 2 ops in flight
        send(2'b00, 32'd9, 32'd9, 4'd12, 3'b000);
        send(2'b00, 32'd8, 32'd8, 4'd13, 3'b000);
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_out_valid", 64'(out_valid), 64'(0));
        check("rstmid_out_result", 64'(out_result), 64'(0));
        check("rstmid_out_rob", 64'(out_rob_idx), 64'(0));
        check("rstmid_out_exc", 64'(out_exception_vector), 64'(0));
        reset = 1'b0;
        count_valid(8, cnt);
        check("rstmid_no_out", 64'(cnt), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
